// File: rtl/sol32_data_responder.sv
// rtl/sol32_data_responder.sv - sol32 data-side responder: word RAM plus MMIO timer with interrupt
// Optional FAULTS counter at MMIO offset 4 is built when SOL32_RESP_FAULTCNT_EN is defined.
module sol32_data_responder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          TIMER_W   = 32
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] MemoryAddress,
    input  logic [31:0] DataOut,
    input  logic        WriteEnable,
    input  logic        Mode,
    output logic [31:0] DataIn,
    output logic        Interrupt
);
    localparam int RAM_WORDS = 1 << ADDR_W;

    logic [31:0]        ram [0:RAM_WORDS-1];
    logic [ADDR_W-1:0]  word_idx;
    logic               ram_hit;
    logic               mmio_hit;
    logic [2:0]         offset;
    logic               mmio_wr;
    logic [31:0]        mmio_rdata;
    logic [31:0]        faults_rdata;
    logic               unused_addr_bits;

    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] compare;
    logic               en;
    logic               autoreload;
    logic               irqen;
    logic               pending;
    logic               irq;
    logic               wr_count;
    logic               wr_compare;
    logic               wr_ctrl;
    logic               wr_status;
    logic               match;

    assign word_idx         = MemoryAddress[ADDR_W+1:2];
    assign ram_hit          = (MemoryAddress[31:ADDR_W+2] == '0);
    assign mmio_hit         = !ram_hit && (MemoryAddress[31:5] == MMIO_BASE[31:5]);
    assign offset           = MemoryAddress[4:2];
    assign mmio_wr          = WriteEnable && mmio_hit && !Mode;
    assign unused_addr_bits = ^MemoryAddress[1:0];

    assign wr_count   = mmio_wr && (offset == 3'd0);
    assign wr_compare = mmio_wr && (offset == 3'd1);
    assign wr_ctrl    = mmio_wr && (offset == 3'd2);
    assign wr_status  = mmio_wr && (offset == 3'd3);
    // A software COUNT write suppresses both increment and match for that cycle.
    assign match      = en && (count == compare) && !wr_count;

    // RAM is deliberately outside the reset domain: contents survive Reset.
    always_ff @(posedge Clock) begin
        if (WriteEnable && ram_hit) begin
            ram[word_idx] <= DataOut;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count      <= '0;
            compare    <= '1;
            en         <= 1'b0;
            autoreload <= 1'b0;
            irqen      <= 1'b0;
            pending    <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_count) begin
                count <= DataOut[TIMER_W-1:0];
            end else if (match) begin
                if (autoreload) begin
                    count <= '0;
                end
            end else if (en) begin
                count <= count + TIMER_W'(1);
            end

            if (wr_compare) begin
                compare <= DataOut[TIMER_W-1:0];
            end

            if (wr_ctrl) begin
                {irqen, autoreload, en} <= DataOut[2:0];
            end else if (match && !autoreload) begin
                en <= 1'b0;
            end

            // Set wins over a simultaneous write-one-to-clear.
            if (match) begin
                pending <= 1'b1;
            end else if (wr_status && DataOut[0]) begin
                pending <= 1'b0;
            end

            irq <= pending && irqen;
        end
    end

`ifdef SOL32_RESP_FAULTCNT_EN
    logic [15:0] faults;
    logic        fault_evt;

    assign fault_evt = WriteEnable && ((!ram_hit && !mmio_hit) || (mmio_hit && Mode));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            faults <= '0;
        end else if (mmio_wr && (offset == 3'd4)) begin
            faults <= '0;
        end else if (fault_evt && (faults != 16'hFFFF)) begin
            faults <= faults + 16'd1;
        end
    end

    assign faults_rdata = {16'h0000, faults};
`else
    assign faults_rdata = 32'd0;
`endif

    always_comb begin
        mmio_rdata = 32'd0;
        case (offset)
            3'd0:    mmio_rdata = 32'(count);
            3'd1:    mmio_rdata = 32'(compare);
            3'd2:    mmio_rdata = {29'd0, irqen, autoreload, en};
            3'd3:    mmio_rdata = {31'd0, pending};
            3'd4:    mmio_rdata = faults_rdata;
            default: mmio_rdata = 32'd0;
        endcase
    end

    assign DataIn    = ram_hit ? ram[word_idx] : (mmio_hit ? mmio_rdata : 32'd0);
    assign Interrupt = irq;

endmodule

// File: tb/tb_sol32_data_responder.sv
// tb/tb_sol32_data_responder.sv - randomized self-checking bench for sol32_data_responder
module tb_sol32_data_responder;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        Clock;
    logic        Reset;
    logic [31:0] MemoryAddress;
    logic [31:0] DataOut;
    logic        WriteEnable;
    logic        Mode;
    logic [31:0] DataIn;
    logic        Interrupt;

    int checks = 0;
    int errors = 0;

    bit [31:0] m_ram [0:1023];
    bit [31:0] m_count;
    bit [31:0] m_cmp;
    bit        m_en, m_ar, m_irqen, m_pend, m_irq;
    int        m_faults;
    bit        model_valid = 0;

    sol32_data_responder dut (
        .Clock(Clock), .Reset(Reset), .MemoryAddress(MemoryAddress), .DataOut(DataOut),
        .WriteEnable(WriteEnable), .Mode(Mode), .DataIn(DataIn), .Interrupt(Interrupt)
    );

    initial Clock = 0;
    always #5 Clock = ~Clock;

    function automatic bit [31:0] model_read(input bit [31:0] a);
        if (a < 32'h1000) return m_ram[a[11:2]];
        if ((a & ~32'h1F) != BASE) return 32'd0;
        case (a[4:2])
            3'd0: return m_count;
            3'd1: return m_cmp;
            3'd2: return 32'(m_en) + 32'(m_ar) * 2 + 32'(m_irqen) * 4;
            3'd3: return 32'(m_pend);
`ifdef SOL32_RESP_FAULTCNT_EN
            3'd4: return 32'(m_faults);
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit [31:0] a;
        bit ram_sel, mmio_sel, sw, matched;
        int off;
        a = MemoryAddress;
        ram_sel = a < 32'h1000;
        mmio_sel = !ram_sel && ((a & ~32'h1F) == BASE);
        off = int'(a[4:2]);
        sw = WriteEnable && mmio_sel && !Mode;
        if (WriteEnable && ram_sel) m_ram[a[11:2]] = DataOut;
        if (Reset) begin
            m_count = 0; m_cmp = 32'hFFFF_FFFF;
            m_en = 0; m_ar = 0; m_irqen = 0; m_pend = 0; m_irq = 0; m_faults = 0;
            return;
        end
`ifdef SOL32_RESP_FAULTCNT_EN
        if (sw && off == 4) m_faults = 0;
        else if (WriteEnable && ((!ram_sel && !mmio_sel) || (mmio_sel && Mode)) && m_faults < 65535)
            m_faults++;
`endif
        m_irq = m_pend && m_irqen;
        matched = m_en && (m_count == m_cmp) && !(sw && off == 0);
        if (sw && off == 0) m_count = DataOut;
        else if (matched) begin
            if (m_ar) m_count = 0;
        end else if (m_en) m_count = m_count + 1;
        if (sw && off == 1) m_cmp = DataOut;
        if (sw && off == 2) begin
            m_en = DataOut[0]; m_ar = DataOut[1]; m_irqen = DataOut[2];
        end else if (matched && !m_ar) m_en = 0;
        if (matched) m_pend = 1;
        else if (sw && off == 3 && DataOut[0]) m_pend = 0;
    endtask

    task automatic drive(input bit [31:0] a, input bit [31:0] d, input bit we, input bit md);
        MemoryAddress = a; DataOut = d; WriteEnable = we; Mode = md;
    endtask

    task automatic tick();
        bit [31:0] exp;
        #1;
        if (model_valid) begin
            exp = model_read(MemoryAddress);
            checks++;
            if (DataIn !== exp) begin
                errors++;
                $display("FAIL pre_edge_read addr=%h: got %h expected %h", MemoryAddress, DataIn, exp);
            end
        end
        model_step();
        @(posedge Clock);
        #1;
        model_valid = 1;
        checks++;
        if (Interrupt !== m_irq) begin
            errors++;
            $display("FAIL interrupt_track: got %b expected %b", Interrupt, m_irq);
        end
        exp = model_read(MemoryAddress);
        checks++;
        if (DataIn !== exp) begin
            errors++;
            $display("FAIL post_edge_read addr=%h: got %h expected %h", MemoryAddress, DataIn, exp);
        end
    endtask

    task automatic peek(input bit [31:0] a, input bit [31:0] exp, input string name);
        MemoryAddress = a; WriteEnable = 0;
        #1;
        checks++;
        if (DataIn !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, DataIn, exp);
        end
    endtask

    task automatic wr(input bit [31:0] a, input bit [31:0] d, input bit md);
        drive(a, d, 1'b1, md);
        tick();
        WriteEnable = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        Reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        peek(BASE + 0, 32'h0, "reset_count");
        peek(BASE + 4, 32'hFFFF_FFFF, "reset_compare");
        peek(BASE + 8, 32'h0, "reset_ctrl");
        peek(BASE + 12, 32'h0, "reset_status");
        checks++;
        if (Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL reset_interrupt: got %b expected 0", Interrupt);
        end
    endtask

    task automatic test_ram();
        drive(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        checks++;
        if (DataIn !== 32'h0) begin
            errors++;
            $display("FAIL ram_read_during_write: got %h expected 0", DataIn);
        end
        tick();
        WriteEnable = 0;
        peek(32'h10, 32'hDEAD_BEEF, "ram_read_aligned");
        peek(32'h13, 32'hDEAD_BEEF, "ram_read_low_bits");
    endtask

    task automatic test_oneshot();
        do_reset();
        wr(BASE + 4, 32'd5, 1'b0);
        wr(BASE + 8, 32'd5, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            drive(BASE + 12, 32'h0, 1'b0, 1'b0);
            tick();
            if (i >= 5) peek(BASE + 12, (i == 6) ? 32'd1 : 32'd0, "oneshot_pending");
        end
        peek(BASE + 0, 32'd5, "oneshot_count_hold");
        peek(BASE + 8, 32'd4, "oneshot_en_cleared");
        checks++;
        if (Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_latency: got %b expected 0", Interrupt);
        end
        tick();
        checks++;
        if (Interrupt !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_irq: got %b expected 1", Interrupt);
        end
        wr(BASE + 12, 32'd1, 1'b0);
        drive(BASE + 12, 32'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_irq_clear: got %b expected 0", Interrupt);
        end
        peek(BASE + 12, 32'd0, "oneshot_status_clear");
    endtask

    task automatic test_autoreload();
        bit [31:0] seq [6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        wr(BASE + 4, 32'd2, 1'b0);
        wr(BASE + 8, 32'd3, 1'b0);
        peek(BASE + 0, seq[0], "autoreload_seq0");
        for (int i = 1; i < 6; i++) begin
            drive(BASE + 0, 32'h0, 1'b0, 1'b0);
            tick();
            peek(BASE + 0, seq[i], "autoreload_seq");
            if (i == 3) peek(BASE + 12, 32'd1, "autoreload_pending");
        end
        wr(BASE + 12, 32'd1, 1'b0);
        peek(BASE + 12, 32'd1, "autoreload_set_wins");
        peek(BASE + 0, 32'd0, "autoreload_wrap");
    endtask

    task automatic test_user_mode();
        do_reset();
        wr(BASE + 4, 32'd7, 1'b1);
        wr(BASE + 8, 32'd7, 1'b1);
        Mode = 1;
        peek(BASE + 4, 32'hFFFF_FFFF, "user_compare_dropped");
        peek(BASE + 8, 32'h0, "user_ctrl_dropped");
        Mode = 0;
    endtask

    task automatic test_unmapped();
        wr(BASE + 16, 32'h0, 1'b0);
        wr(32'h8000_0000, 32'h1234_5678, 1'b0);
        peek(32'h8000_0000, 32'h0, "unmapped_read");
        peek(32'h10, 32'hDEAD_BEEF, "unmapped_no_ram_change");
        peek(BASE + 20, 32'h0, "reserved_offset5");
`ifdef SOL32_RESP_FAULTCNT_EN
        peek(BASE + 16, 32'd1, "faults_one");
`else
        peek(BASE + 16, 32'd0, "offset4_reads_zero");
`endif
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        wr(BASE + 0, 32'd3, 1'b0);
        wr(BASE + 8, 32'd5, 1'b0);
        Reset = 1;
        drive(BASE + 0, 32'd99, 1'b1, 1'b0);
        tick();
        Reset = 0;
        WriteEnable = 0;
        peek(BASE + 0, 32'd0, "midreset_count");
        peek(BASE + 8, 32'd0, "midreset_ctrl");
        peek(32'h10, 32'hDEAD_BEEF, "midreset_ram_kept");
        checks++;
        if (Interrupt !== 1'b0) begin
            errors++;
            $display("FAIL midreset_interrupt: got %b expected 0", Interrupt);
        end
    endtask

    task automatic test_random();
        bit [31:0] a, d;
        int sel, off;
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            d = $urandom;
            if (sel < 4) a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            else if (sel < 8) begin
                off = $urandom_range(0, 7);
                a = BASE + 32'(off * 4);
                if (off <= 1) d = $urandom_range(0, 12);
                if (off == 2) d = $urandom_range(0, 7);
            end else if (sel == 8) a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            else a = $urandom_range(0, 32'hFFF);
            Reset = ($urandom_range(0, 199) == 0);
            drive(a, d, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            tick();
        end
        Reset = 0;
    endtask

`ifdef SOL32_RESP_FAULTCNT_EN
    task automatic test_faults_saturate();
        do_reset();
        for (int n = 0; n < 70000; n++) begin
            drive(32'h8000_0000, 32'h0, 1'b1, 1'b0);
            tick();
        end
        WriteEnable = 0;
        peek(BASE + 16, 32'h0000_FFFF, "faults_saturate");
    endtask
`endif

    initial begin
        Reset = 1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_ram();
        test_oneshot();
        test_autoreload();
        test_user_mode();
        test_unmapped();
        test_reset_mid_count();
        test_random();
`ifdef SOL32_RESP_FAULTCNT_EN
        test_faults_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
